// File: rtl/serial_sync_tx_if.sv
// Payload handshake between a word source and the serial frame transmitter.
interface serial_sync_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/serial_sync_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, optional even parity,
// then a fixed idle gap. One line bit per clock, all outputs registered.
//
// state | meaning
// IDLE  | line at idle level, ready for a payload word
// SYNC  | shifting out the sync pattern MSB-first
// DATA  | shifting out the latched payload MSB-first
// PAR   | even-parity bit on the line
// GAP   | idle level for GAP_LEN bits, then frame_done
module serial_sync_tx #(
  parameter int unsigned         SYNC_LEN     = 4,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b0100,
  parameter int unsigned         DATA_W       = 8,
  parameter bit                  PARITY_EN    = 1'b1,
  parameter int unsigned         GAP_LEN      = 2,
  parameter logic                IDLE_LVL     = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  serial_sync_tx_if.slave        tx,
  output logic                   q_out,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int unsigned MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int unsigned MAX_LEN = (MAX_SD > GAP_LEN) ? MAX_SD : GAP_LEN;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [SYNC_LEN-1:0] sync_q, sync_d;
  logic                par_q, par_d;
  logic                q_q, q_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic                cnt_tc;

  assign cnt_tc = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sync_q  <= '0;
      par_q   <= 1'b0;
      q_q     <= IDLE_LVL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sync_q  <= sync_d;
      par_q   <= par_d;
      q_q     <= q_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (tx.data_valid) state_d = ST_SYNC;
      ST_SYNC: if (cnt_tc) state_d = ST_DATA;
      ST_DATA: if (cnt_tc) state_d = PARITY_EN ? ST_PAR : ST_GAP;
      ST_PAR:  state_d = ST_GAP;
      ST_GAP:  if (cnt_tc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every branch computes the value the line carries after this edge, so the
  // sync MSB goes out on the accepting edge itself.
  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    sync_d  = sync_q;
    par_d   = par_q;
    q_d     = q_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        q_d     = IDLE_LVL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (tx.data_valid) begin
          shreg_d = tx.data_in;
          par_d   = ^tx.data_in;
          sync_d  = SYNC_PATTERN << 1;
          q_d     = SYNC_PATTERN[SYNC_LEN-1];
          cnt_d   = SYNC_LAST;
          start_d = 1'b1;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SYNC: begin
        if (cnt_tc) begin
          q_d     = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = DATA_LAST;
        end else begin
          q_d    = sync_q[SYNC_LEN-1];
          sync_d = sync_q << 1;
          cnt_d  = cnt_q - CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_tc) begin
          if (PARITY_EN) begin
            q_d   = par_q;
            cnt_d = '0;
          end else begin
            q_d   = IDLE_LVL;
            cnt_d = GAP_LAST;
          end
        end else begin
          q_d     = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_PAR: begin
        q_d   = IDLE_LVL;
        cnt_d = GAP_LAST;
      end
      ST_GAP: begin
        q_d = IDLE_LVL;
        if (cnt_tc) begin
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        q_d     = IDLE_LVL;
        cnt_d   = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign q_out         = q_q;
  assign tx.data_ready = ready_q;
  assign busy          = busy_q;
  assign frame_start   = start_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_serial_sync_tx.sv
// Bench for serial_sync_tx: default instance plus a no-parity, one-bit-gap instance,
// line bits checked against a scoreboard of model frames.
module tb_serial_sync_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_sync_tx_if #(.DATA_W(8)) a_if ();
  serial_sync_tx_if #(.DATA_W(8)) b_if ();

  logic q_a, fs_a, fd_a, busy_a;
  logic q_b, fs_b, fd_b, busy_b;

  serial_sync_tx #(.DATA_W(8)) dut_a (
    .clk(clk), .reset(reset), .tx(a_if.slave),
    .q_out(q_a), .frame_start(fs_a), .frame_done(fd_a), .busy(busy_a)
  );

  serial_sync_tx #(.DATA_W(8), .PARITY_EN(1'b0), .GAP_LEN(1)) dut_b (
    .clk(clk), .reset(reset), .tx(b_if.slave),
    .q_out(q_b), .frame_start(fs_b), .frame_done(fd_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  logic exp_a[$];
  logic exp_b[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_bit(input logic b, input bit to_b);
    if (to_b) exp_b.push_back(b);
    else      exp_a.push_back(b);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic p, input bit par_en,
                            input int gap, input bit to_b);
    logic [3:0] sp;
    sp = 4'b0100;
    for (int i = 3; i >= 0; i--) push_bit(sp[i], to_b);
    for (int i = 7; i >= 0; i--) push_bit(d[i], to_b);
    if (par_en) push_bit(p, to_b);
    for (int i = 0; i < gap; i++) push_bit(1'b1, to_b);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && busy_a === 1'b1) begin
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL line_a: unexpected bit %b with empty scoreboard at %0t", q_a, $time);
      end else begin
        logic e;
        e = exp_a.pop_front();
        if (q_a !== e) begin
          errors++;
          $display("FAIL line_a: got %b expected %b at %0t", q_a, e, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0 && busy_b === 1'b1) begin
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL line_b: unexpected bit %b with empty scoreboard at %0t", q_b, $time);
      end else begin
        logic e;
        e = exp_b.pop_front();
        if (q_b !== e) begin
          errors++;
          $display("FAIL line_b: got %b expected %b at %0t", q_b, e, $time);
        end
      end
    end
  end

  // Reference 0100 pattern detector watching line A
  logic [3:0] hist_a = 4'hF;
  int det_a = 0;
  always @(negedge clk) begin
    if ({hist_a[2:0], q_a} == 4'b0100) det_a++;
    hist_a = {hist_a[2:0], q_a};
  end

  task automatic send_a(input logic [7:0] d, input logic p);
    int lowc;
    a_if.data_in    = d;
    a_if.data_valid = 1'b1;
    push_frame(d, p, 1'b1, 2, 1'b0);
    @(posedge clk); #1;
    a_if.data_valid = 1'b0;
    chk("start_pulse", fs_a, 1);
    chk("ready_drop", a_if.data_ready, 0);
    chk("busy_rise", busy_a, 1);
    @(posedge clk); #1;
    chk("start_single", fs_a, 0);
    lowc = 1;
    while (a_if.data_ready !== 1'b1 && lowc < 40) begin
      lowc++;
      @(posedge clk); #1;
    end
    chk("ready_low_cycles", lowc, 15);
    chk("done_pulse", fd_a, 1);
    chk("busy_fall", busy_a, 0);
    @(posedge clk); #1;
    chk("done_single", fd_a, 0);
    chk("line_idle", q_a, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lowc;
    int d0;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h01, 1'b1};
    vecs[2] = '{8'h3C, 1'b0};
    vecs[3] = '{8'hC3, 1'b0};
    vecs[4] = '{8'hFF, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h00, 1'b0};
    vecs[7] = '{8'h7F, 1'b1};

    reset = 1'b1;
    a_if.data_in = '0; a_if.data_valid = 1'b0;
    b_if.data_in = '0; b_if.data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q_out", q_a, 1);
    chk("rst_ready", a_if.data_ready, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_start", fs_a, 0);
    chk("rst_done", fd_a, 0);
    reset = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold_q", q_a, 1);
    chk("idle_hold_ready", a_if.data_ready, 1);
    chk("idle_hold_busy", busy_a, 0);

    for (int i = 0; i < 8; i++) send_a(vecs[i].data, vecs[i].par);

    d0 = det_a;
    send_a(8'hFF, 1'b0);
    chk("loopback_detects", det_a - d0, 1);

    // back-to-back with data_valid held high
    a_if.data_in    = 8'h3C;
    a_if.data_valid = 1'b1;
    push_frame(8'h3C, 1'b0, 1'b1, 2, 1'b0);
    @(posedge clk); #1;
    chk("b2b_start1", fs_a, 1);
    a_if.data_in = 8'hC3;
    push_frame(8'hC3, 1'b0, 1'b1, 2, 1'b0);
    lowc = 0;
    while (fd_a !== 1'b1 && lowc < 40) begin
      lowc++;
      @(posedge clk); #1;
    end
    chk("b2b_done1_edge", lowc, 15);
    chk("b2b_ready_up", a_if.data_ready, 1);
    @(posedge clk); #1;
    chk("b2b_start2", fs_a, 1);
    chk("b2b_done_clear", fd_a, 0);
    chk("b2b_ready_down", a_if.data_ready, 0);
    chk("b2b_sync_msb", q_a, 0);
    a_if.data_valid = 1'b0;
    lowc = 0;
    while (fd_a !== 1'b1 && lowc < 40) begin
      lowc++;
      @(posedge clk); #1;
    end
    chk("b2b_done2_edge", lowc, 15);
    @(posedge clk); #1;

    // abort during payload bit 3
    a_if.data_in    = 8'h5A;
    a_if.data_valid = 1'b1;
    push_frame(8'h5A, 1'b0, 1'b1, 2, 1'b0);
    @(posedge clk); #1;
    a_if.data_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_q_out", q_a, 1);
    chk("abort_ready", a_if.data_ready, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_no_done", fd_a, 0);
    reset = 1'b0;
    exp_a.delete();
    @(posedge clk); #1;
    chk("abort_no_done_later", fd_a, 0);
    send_a(8'h01, 1'b1);

    // no parity, one-bit gap
    b_if.data_in    = 8'hFF;
    b_if.data_valid = 1'b1;
    push_frame(8'hFF, 1'b0, 1'b0, 1, 1'b1);
    @(posedge clk); #1;
    b_if.data_valid = 1'b0;
    chk("b_start_pulse", fs_b, 1);
    lowc = 0;
    while (b_if.data_ready !== 1'b1 && lowc < 40) begin
      lowc++;
      @(posedge clk); #1;
    end
    chk("b_ready_low_cycles", lowc, 13);
    chk("b_done_pulse", fd_b, 1);
    @(posedge clk); #1;
    chk("b_line_idle", q_b, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_a_drained", exp_a.size(), 0);
    chk("scoreboard_b_drained", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_sync_tx.md
Name: serial_sync_tx

Overview:
- Serial frame transmitter: the transmit-side counterpart of the team's Mealy serial sync-pattern detector.
- Accepts a parallel payload word through a valid/ready handshake and drives a one-bit serial line: sync pattern, then payload MSB-first, then optional even parity, then a mandatory idle gap.
- Drives the line that the detector-side logic samples. Also serves as the stimulus source for detector verification.

Parameters:
- SYNC_LEN, 4, number of sync bits (1..16).
- SYNC_PATTERN, 4'b0100, sync bits, transmitted MSB-first.
- DATA_W, 8, payload width (1..32).
- PARITY_EN, 1, 1 = append an even-parity bit after the payload; 0 = no parity bit.
- GAP_LEN, 2, idle bits after each frame (1..15, minimum 1).
- IDLE_LVL, 1'b1, line level outside frames.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  payload word.
- data_valid  input  1  payload word available.
- data_ready  output  1  transmitter can accept a payload word.
- q_out  output  1  serial line, registered.
- frame_start  output  1  one-cycle pulse, coincident with the first sync bit on q_out.
- frame_done  output  1  one-cycle pulse, coincident with data_ready returning high.
- busy  output  1  high while a frame (including its gap) is in progress.

Behaviour:
- Clocking/reset: reset is synchronous, active-high; clock is clk. All outputs are registered.
- Reset values: q_out=IDLE_LVL, data_ready=1, busy=0, frame_start=0, frame_done=0, state=IDLE, all counters 0.
- Reset mid-frame: the frame is aborted with no frame_done. At the next edge, q_out=IDLE_LVL and data_ready=1.
- State machine: IDLE, SYNC, DATA, PAR, GAP. One bit is output per clock.
- IDLE:
  - data_ready=1, busy=0, q_out=IDLE_LVL.
  - On an edge with data_valid=1, latch data_in into the shift register and compute parity = XOR of data_in.
  - Same edge: q_out<=SYNC_PATTERN[SYNC_LEN-1], frame_start<=1, data_ready<=0, busy<=1, go to SYNC.
  - data_in is not sampled in any other state.
- SYNC: output the remaining sync bits MSB-first. After SYNC_LEN bit-cycles, the next edge drives q_out<=payload MSB and goes to DATA.
- DATA:
  - Shift the payload MSB-first for DATA_W cycles.
  - After the last payload bit: if PARITY_EN=1, q_out<=parity and go to PAR; otherwise q_out<=IDLE_LVL and go to GAP.
- PAR: one cycle; then q_out<=IDLE_LVL, go to GAP.
- GAP:
  - Hold q_out=IDLE_LVL for GAP_LEN cycles.
  - The edge ending the gap sets data_ready<=1, busy<=0, frame_done<=1, and goes to IDLE.
- Frame length: data_ready is low for exactly F = SYNC_LEN + DATA_W + PARITY_EN + GAP_LEN cycles (15 at defaults).
- Back-to-back: if data_valid is held high, the next frame is accepted on the first edge after data_ready rises. The line therefore shows exactly GAP_LEN idle bits between frames; there is no extra idle cycle because the sync MSB is driven on that accepting edge.
- Pulses: frame_start and frame_done are single-cycle pulses and never overlap each other. frame_done of frame N precedes frame_start of frame N+1 by at least one cycle.
- Counter: the bit counter is sized ceil(log2(max(SYNC_LEN, DATA_W, GAP_LEN)+1)) and reloads at each state change. It has no wrap-around dependency.
- data_valid low in IDLE: remain in IDLE; the line stays at IDLE_LVL indefinitely.

Test Plan:
- Single frame, defaults: reset, then data_in=8'hA5 with data_valid for 1 cycle -> q_out sequence 0,1,0,0, 1,0,1,0,0,1,0,1, 0 (parity), 1,1. frame_start on cycle 1, frame_done on cycle 16, data_ready low for 15 cycles.
- Odd parity payload: data_in=8'h01 -> parity bit 1; payload bits 0,0,0,0,0,0,0,1.
- Back-to-back: data_valid held high with 8'h3C then 8'hC3 -> exactly 2 idle '1' bits between frames. The second sync MSB appears the edge after data_ready rises; 30 bit-cycles total.
- Reset mid-frame: assert reset during payload bit 3 -> next edge q_out=1, data_ready=1, busy=0, no frame_done. A new frame then transmits correctly.
- PARITY_EN=0, GAP_LEN=1: data_in=8'hFF -> 0100, 11111111, 1. data_ready low for 13 cycles.
- Loopback: feed q_out into the team's serial sync-pattern detector -> one detect per frame when the payload contains no embedded 0100, e.g. 8'hFF.
